// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants and helpers for the 7-segment scan driver.
// Holds the 16-entry active-low glyph table ({dp,g,f,e,d,c,b,a}, dp always off),
// the dark-output constants and the one-hot-low anode helper.
package ssd_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Index = digit code 0..F.
  localparam logic [7:0] GLYPH_TAB [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Active-low anode select: only bit idx is driven low.
  function automatic logic [3:0] an_onehot(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/ssd_glyph_rom.sv
// ssd_glyph_rom: combinational digit-code to 7-segment pattern lookup.
// Ports: code (DIG_W-bit digit code) in, seg (8-bit active-low {dp,g,f,e,d,c,b,a}) out.
// Zero latency; no flow control.
module ssd_glyph_rom
  import ssd_pkg::*;
#(
  parameter int DIG_W = 3
) (
  input  logic [DIG_W-1:0] code,
  output logic [7:0]       seg
);

  // Widen to a 4-bit table index; works for DIG_W of 3 or 4.
  logic [3:0] code4;

  always_comb begin
    code4 = '0;
    code4[DIG_W-1:0] = code;
  end

  assign seg = GLYPH_TAB[code4];

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexes four digit codes onto a common-anode
// 4-digit 7-segment display, snapshotting the digit bus once per frame.
// Ports: clk, rst_n (sync, active-low), en, d0..d3, blank[3:0] in;
// ssd_an[3:0], ssd_seg[7:0] (both active-low) and frame_done pulse out.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DIG_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIG_W-1:0] d0,
  input  logic [DIG_W-1:0] d1,
  input  logic [DIG_W-1:0] d2,
  input  logic [DIG_W-1:0] d3,
  input  logic [3:0]       blank,
  output logic [3:0]       ssd_an,
  output logic [7:0]       ssd_seg,
  output logic             frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [DIG_W-1:0] sh_dig [4];
  logic [3:0]       sh_blank;
  logic             load_pending;

  logic             tick;
  logic             load;
  logic [DIG_W-1:0] live_code;
  logic [DIG_W-1:0] cur_code;
  logic [3:0]       cur_blank;
  logic [7:0]       cur_seg;

  assign tick = en && (cnt == CNT_LAST);
  assign load = en && (load_pending || (tick && (idx == 2'd3)));

  always_comb begin
    live_code = d0;
    case (idx)
      2'd0: live_code = d0;
      2'd1: live_code = d1;
      2'd2: live_code = d2;
      2'd3: live_code = d3;
      default: live_code = d0;
    endcase
  end

  // The first snapshot after reset happens on the same edge that lights
  // digit 0, so that frame reads the live bus; this gives digit 0 its full
  // dwell. Every later frame reads only the shadow, which keeps a mid-frame
  // rotation from tearing the image.
  assign cur_code  = load_pending ? live_code : sh_dig[idx];
  assign cur_blank = load_pending ? blank     : sh_blank;

  ssd_glyph_rom #(.DIG_W(DIG_W)) u_rom (
    .code (cur_code),
    .seg  (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      for (int i = 0; i < 4; i++) sh_dig[i] <= '0;
      sh_blank     <= 4'b1111;
      load_pending <= 1'b1;
      ssd_an       <= AN_OFF;
      ssd_seg      <= SEG_OFF;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= load;

      // Prescaler and index hold while disabled.
      if (en) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) idx <= idx + 2'd1;
      end

      if (load) begin
        sh_dig[0]    <= d0;
        sh_dig[1]    <= d1;
        sh_dig[2]    <= d2;
        sh_dig[3]    <= d3;
        sh_blank     <= blank;
        load_pending <= 1'b0;
      end

      if (!en || cur_blank[idx]) begin
        ssd_an  <= AN_OFF;
        ssd_seg <= SEG_OFF;
      end else begin
        ssd_an  <= an_onehot(idx);
        ssd_seg <= cur_seg;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: directed bench for ssd_scan_driver with SCAN_DIV=4, DIG_W=3.
// k counts rising edges since reset release; outputs are sampled 1 time unit
// after each edge and compared against hand-derived values.
module tb_ssd_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] d0, d1, d2, d3;
  logic [3:0] blank;
  logic [3:0] ssd_an;
  logic [7:0] ssd_seg;
  logic       frame_done;

  int tests = 0;
  int fails = 0;
  int k = 0;

  always #5 clk = ~clk;

  ssd_scan_driver #(.SCAN_DIV(4), .DIG_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .blank      (blank),
    .ssd_an     (ssd_an),
    .ssd_seg    (ssd_seg),
    .frame_done (frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s at k=%0d: observed %h expected %h", tag, k, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] an_e,
                           input logic [7:0] seg_e, input logic fd_e);
    chk({tag, "_an"},  {4'h0, ssd_an},     {4'h0, an_e});
    chk({tag, "_seg"}, ssd_seg,            seg_e);
    chk({tag, "_fd"},  {7'h0, frame_done}, {7'h0, fd_e});
  endtask

  // Advance to edge 'upto', checking every cycle on the way; frame_done is
  // expected high only at edge fd_k.
  task automatic span(input int upto, input string tag, input logic [3:0] an_e,
                      input logic [7:0] seg_e, input int fd_k);
    while (k < upto) begin
      step();
      chk_state(tag, an_e, seg_e, k == fd_k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; blank = 4'b0000;
    d0 = 3'd0; d1 = 3'd1; d2 = 3'd2; d3 = 3'd3;
    step(); step();
    chk_state("reset", 4'hF, 8'hFF, 1'b0);

    rst_n = 1'b1; en = 1'b1; k = 0;

    // Frame 1: digits 0,1,2,3; change the bus while digit 1 is lit.
    span(1,  "f1_first", 4'hE, 8'hC0, 1);
    span(4,  "f1_d0",    4'hE, 8'hC0, -1);
    span(6,  "f1_d1a",   4'hD, 8'hF9, -1);
    d0 = 3'd1; d1 = 3'd2; d2 = 3'd3; d3 = 3'd4;
    span(8,  "f1_d1b",   4'hD, 8'hF9, -1);
    span(12, "f1_d2",    4'hB, 8'hA4, -1);
    span(16, "f1_d3",    4'h7, 8'hB0, 16);

    // Frame 2: rotated digits 1,2,3,4.
    span(20, "f2_d0",    4'hE, 8'hF9, -1);
    span(24, "f2_d1",    4'hD, 8'hA4, -1);
    span(28, "f2_d2",    4'hB, 8'hB0, -1);
    span(30, "f2_d3a",   4'h7, 8'h99, -1);
    blank = 4'b0100; d2 = 3'd5;
    span(32, "f2_d3b",   4'h7, 8'h99, 32);

    // Frame 3: digit 2 blanked.
    span(36, "f3_d0",    4'hE, 8'hF9, -1);
    span(40, "f3_d1",    4'hD, 8'hA4, -1);
    span(44, "f3_blank", 4'hF, 8'hFF, -1);
    span(46, "f3_d3a",   4'h7, 8'h99, -1);
    blank = 4'b0000;
    span(48, "f3_d3b",   4'h7, 8'h99, 48);

    // Frame 4: pause for 6 cycles one cycle into digit 1.
    span(52, "f4_d0",    4'hE, 8'hF9, -1);
    span(53, "f4_d1a",   4'hD, 8'hA4, -1);
    en = 1'b0;
    span(59, "f4_off",   4'hF, 8'hFF, -1);
    en = 1'b1;
    span(62, "f4_d1b",   4'hD, 8'hA4, -1);
    span(66, "f4_d2",    4'hB, 8'h92, -1);
    span(68, "f4_d3",    4'h7, 8'h99, -1);

    // Reset mid-digit-3 with new digits 7,6,5,4.
    rst_n = 1'b0;
    d0 = 3'd7; d1 = 3'd6; d2 = 3'd5; d3 = 3'd4;
    span(69, "rst_mid",  4'hF, 8'hFF, -1);
    rst_n = 1'b1;
    span(70, "rst_snap", 4'hE, 8'hF8, 70);
    span(73, "rst_d0",   4'hE, 8'hF8, -1);
    span(74, "rst_d1",   4'hD, 8'h82, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
